// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: next-PC select encodings, nop/halt
// encodings and the IF/ID payload layout.
package pipeline_defs;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_JR     = 2'b11;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] instruction;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: load, hold or flush to nop.
// Ports: clk, reset (sync, active-high), load (capture instr/pc4 as valid),
//        flush (clear to nop), instr_d/pc4_d (incoming fetch), if_id (held payload).
// With neither load nor flush asserted the register holds.
module if_id_register
    import pipeline_defs::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] instr_d,
    input  logic [XLEN-1:0] pc4_d,
    output if_id_t          if_id
);

    // Flush takes precedence over load so a squash can never leak a word
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            if_id.instruction <= NOP_INSTR;
            if_id.pc4         <= '0;
            if_id.valid       <= 1'b0;
        end else if (load) begin
            if_id.instruction <= instr_d;
            if_id.pc4         <= pc4_d;
            if_id.valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, drives the instruction memory address, selects the
// next PC (sequential/branch/jump/jr), and latches fetched words into IF/ID.
// Handles stall hold, squash on redirect, halt on opcode 6'b111111 and a
// sticky fault for out-of-range or misaligned fetches.
// Ports: CLK, Reset (sync, active-high), Stall, PCSrc, BranchTarget, JumpIndex,
//        JrTarget, IMemData in; IMemAddr (= PC, combinational), PC,
//        IF_ID_PC4, IF_ID_Instruction, IF_ID_Valid, Halted, FetchFault out.
module instruction_fetch_stage
    import pipeline_defs::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 128
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Stall,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] JrTarget,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemData,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_PC4,
    output logic [31:0] IF_ID_Instruction,
    output logic        IF_ID_Valid,
    output logic        Halted,
    output logic        FetchFault
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fault_q, fault_d;
    logic        ifid_load, ifid_flush;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] redirect_target;
    logic        fetch_bad;
    logic        halt_word;
    if_id_t      if_id;

    assign pc_plus4    = pc_q + 32'd4;
    assign jump_target = {if_id.pc4[31:28], JumpIndex, 2'b00};
    assign fetch_bad   = (pc_q >= 32'(IMEM_BYTES)) || (pc_q[1:0] != 2'b00);
    assign halt_word   = (IMemData[31:26] == HALT_OPCODE);

    // Redirect target select; PCSRC_SEQ is never used here
    always_comb begin
        redirect_target = BranchTarget;
        case (PCSrc)
            PCSRC_BRANCH: redirect_target = BranchTarget;
            PCSRC_JUMP:   redirect_target = jump_target;
            PCSRC_JR:     redirect_target = JrTarget;
            default:      redirect_target = pc_plus4;
        endcase
    end

    // State, PC and fault registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    // Next-state / next-PC / IF-ID control; priority stall > redirect > fault > halt > normal
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (Stall) begin
                    // everything holds; PCSrc is reasserted by the hazard unit
                end else if (PCSrc != PCSRC_SEQ) begin
                    // wrong-path fetch squashed, halt words included
                    pc_d       = redirect_target;
                    ifid_flush = 1'b1;
                end else if (fetch_bad) begin
                    // a bad fetch cannot be a halt; keep walking so the fault stays visible
                    pc_d       = pc_plus4;
                    fault_d    = 1'b1;
                    ifid_flush = 1'b1;
                end else if (halt_word) begin
                    ifid_load  = 1'b1;
                    state_d    = ST_HALTED;
                end else begin
                    pc_d       = pc_plus4;
                    ifid_load  = 1'b1;
                end
            end
            ST_HALTED: begin
                ifid_flush = !Stall;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    if_id_register u_if_id (
        .clk     (CLK),
        .reset   (Reset),
        .load    (ifid_load),
        .flush   (ifid_flush),
        .instr_d (IMemData),
        .pc4_d   (pc_plus4),
        .if_id   (if_id)
    );

    assign IMemAddr          = pc_q;
    assign PC                = pc_q;
    assign IF_ID_PC4         = if_id.pc4;
    assign IF_ID_Instruction = if_id.instruction;
    assign IF_ID_Valid       = if_id.valid;
    assign Halted            = (state_q == ST_HALTED);
    assign FetchFault        = fault_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  pcsrc;
    logic [31:0] branch_target;
    logic [25:0] jump_index;
    logic [31:0] jr_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic        fetch_fault;

    logic [31:0] mem [0:31];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // combinational instruction memory; out of range reads return 0
    assign imem_data = (imem_addr < 32'd128) ? mem[imem_addr[6:2]] : 32'h0;

    instruction_fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (128)
    ) dut (
        .CLK               (clk),
        .Reset             (reset),
        .Stall             (stall),
        .PCSrc             (pcsrc),
        .BranchTarget      (branch_target),
        .JumpIndex         (jump_index),
        .JrTarget          (jr_target),
        .IMemAddr          (imem_addr),
        .IMemData          (imem_data),
        .PC                (pc),
        .IF_ID_PC4         (if_id_pc4),
        .IF_ID_Instruction (if_id_instr),
        .IF_ID_Valid       (if_id_valid),
        .Halted            (halted),
        .FetchFault        (fetch_fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // one active edge; inputs change and outputs are sampled on the falling edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic valid);
        check_eq({tag, ".instr"}, if_id_instr, instr);
        check_eq({tag, ".pc4"},   if_id_pc4,   pc4);
        check_eq({tag, ".valid"}, 32'(if_id_valid), 32'(valid));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0]  = 32'h2401_0008;
        mem[1]  = 32'h3402_0002;
        mem[20] = 32'h2003_0005;   // 0x50
        mem[23] = 32'hFC00_0000;   // 0x5C halt

        reset = 1'b1; stall = 1'b0; pcsrc = 2'b00;
        branch_target = '0; jump_index = '0; jr_target = '0;
        @(negedge clk);
        step(1);
        check_eq("rst.pc", pc, 32'h0);
        check_eq("rst.imemaddr", imem_addr, 32'h0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check_eq("rst.halted", 32'(halted), 32'h0);
        check_eq("rst.fault", 32'(fetch_fault), 32'h0);
        reset = 1'b0;

        // sequential fetch
        step(1);
        check_ifid("seq1", 32'h2401_0008, 32'h4, 1'b1);
        step(1);
        check_ifid("seq2", 32'h3402_0002, 32'h8, 1'b1);
        check_eq("seq2.pc", pc, 32'h8);

        // walk to IF_ID_PC4 = 0x20, then jump
        step(6);
        check_eq("prejump.pc4", if_id_pc4, 32'h20);
        pcsrc = 2'b10; jump_index = 26'h14;
        step(1);
        check_eq("jump.pc", pc, 32'h50);
        check_eq("jump.imemaddr", imem_addr, 32'h50);
        check_ifid("jump.bubble", 32'h0, 32'h0, 1'b0);
        pcsrc = 2'b00;
        step(1);
        check_ifid("jump.fetch", 32'h2003_0005, 32'h54, 1'b1);
        check_eq("jump.fetch.pc", pc, 32'h54);

        // stall with a redirect asserted throughout
        stall = 1'b1; pcsrc = 2'b01; branch_target = 32'h10;
        step(3);
        check_eq("stall.pc", pc, 32'h54);
        check_ifid("stall", 32'h2003_0005, 32'h54, 1'b1);
        stall = 1'b0;
        step(1);
        check_eq("branch.pc", pc, 32'h10);
        check_ifid("branch", 32'h0, 32'h0, 1'b0);
        pcsrc = 2'b00;

        // run into the halt word at 0x5C
        step(19);
        check_eq("prehalt.pc", pc, 32'h5C);
        step(1);
        check_ifid("halt", 32'hFC00_0000, 32'h60, 1'b1);
        check_eq("halt.pc", pc, 32'h5C);
        check_eq("halt.halted", 32'(halted), 32'h1);
        pcsrc = 2'b10; jump_index = 26'h1;
        step(1);
        check_ifid("halted.nop", 32'h0, 32'h0, 1'b0);
        check_eq("halted.pc", pc, 32'h5C);
        check_eq("halted.still", 32'(halted), 32'h1);
        pcsrc = 2'b00;
        reset = 1'b1; stall = 1'b1;
        step(1);
        check_eq("halt.rst.pc", pc, 32'h0);
        check_eq("halt.rst.halted", 32'(halted), 32'h0);
        check_ifid("halt.rst", 32'h0, 32'h0, 1'b0);
        reset = 1'b0; stall = 1'b0;

        // halt word on the wrong path is squashed
        pcsrc = 2'b01; branch_target = 32'h5C;
        step(1);
        check_eq("wp.pc0", pc, 32'h5C);
        branch_target = 32'h18;
        step(1);
        check_eq("wp.halted", 32'(halted), 32'h0);
        check_eq("wp.pc", pc, 32'h18);
        check_ifid("wp", 32'h0, 32'h0, 1'b0);

        // misaligned jr faults on the following fetch
        pcsrc = 2'b11; jr_target = 32'h82;
        step(1);
        check_eq("jr.pc", pc, 32'h82);
        check_eq("jr.fault0", 32'(fetch_fault), 32'h0);
        pcsrc = 2'b00;
        step(1);
        check_eq("fault.flag", 32'(fetch_fault), 32'h1);
        check_eq("fault.pc", pc, 32'h86);
        check_ifid("fault", 32'h0, 32'h0, 1'b0);
        step(1);
        check_eq("fault.sticky", 32'(fetch_fault), 32'h1);
        check_eq("fault.pc2", pc, 32'h8A);
        reset = 1'b1;
        step(1);
        check_eq("fault.rst", 32'(fetch_fault), 32'h0);
        reset = 1'b0;

        // aligned but past the end of memory
        pcsrc = 2'b11; jr_target = 32'h80;
        step(1);
        pcsrc = 2'b00;
        step(1);
        check_eq("oor.fault", 32'(fetch_fault), 32'h1);
        check_eq("oor.pc", pc, 32'h84);
        check_eq("oor.valid", 32'(if_id_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
